rf_wb_ctrl: RTL and testbench



---
 rtl/rf_wb_ctrl.sv | 121 ++++++++++++
 tb/tb_rf_wb_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: write-port owner for the 2R1W integer register file.
// After reset it zeroes x1..x(RF_WORDS-1), one register per cycle, then
// arbitrates ALU and LSU writebacks onto the single write port (LSU first).
// A write to x0 is never presented on the port.
//
// Ports:
//   clk, rst_n           clock; asynchronous active-low reset
//   i_alu_valid/addr/data ALU writeback request; o_alu_ready accepts it
//   i_lsu_valid/addr/data LSU writeback request; o_lsu_ready accepts it
//   o_wen/o_waddr/o_wdata registered register-file write port
//   o_init_done           registered, high once the zeroing sweep is complete
//
// Optional build macro RF_WB_BYPASS_EN adds same-cycle write forwarding:
//   i_raddr_a/i_raddr_b   decode-stage read addresses
//   o_byp_a_hit/b_hit     the write on the port targets that read address
//   o_byp_data            data to forward in place of register-file data
module rf_wb_ctrl #(
   parameter int DLEN = 32,
   parameter int ALEN = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_alu_valid,
   input  logic [ALEN-1:0] i_alu_addr,
   input  logic [DLEN-1:0] i_alu_data,
   output logic            o_alu_ready,
   input  logic            i_lsu_valid,
   input  logic [ALEN-1:0] i_lsu_addr,
   input  logic [DLEN-1:0] i_lsu_data,
   output logic            o_lsu_ready,
   output logic            o_wen,
   output logic [ALEN-1:0] o_waddr,
   output logic [DLEN-1:0] o_wdata,
   output logic            o_init_done
`ifdef RF_WB_BYPASS_EN
   ,
   input  logic [ALEN-1:0] i_raddr_a,
   input  logic [ALEN-1:0] i_raddr_b,
   output logic            o_byp_a_hit,
   output logic            o_byp_b_hit,
   output logic [DLEN-1:0] o_byp_data
`endif
);
   localparam int RF_WORDS = 1 << ALEN;
   localparam logic [ALEN-1:0] LAST = ALEN'(RF_WORDS - 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t          state_q, state_d;
   logic [ALEN-1:0] cnt_q, cnt_d;
   logic            wen_q, wen_d;
   logic [ALEN-1:0] waddr_q, waddr_d;
   logic [DLEN-1:0] wdata_q, wdata_d;
   logic            done_q, done_d;
   logic            run, lsu_acc, alu_acc;
   logic [ALEN-1:0] acc_addr;
   logic [DLEN-1:0] acc_data;

   assign run         = state_q == RUN;
   assign o_lsu_ready = run;
   assign o_alu_ready = run & ~i_lsu_valid;
   assign lsu_acc     = i_lsu_valid & o_lsu_ready;
   assign alu_acc     = i_alu_valid & o_alu_ready;
   assign acc_addr    = lsu_acc ? i_lsu_addr : i_alu_addr;
   assign acc_data    = lsu_acc ? i_lsu_data : i_alu_data;

   // Port address/data only move on a real write, so an x0 accept or an idle
   // cycle leaves them at their last values with the enable low.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wen_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      done_d  = done_q;
      if (state_q == INIT) begin
         wen_d   = 1'b1;
         waddr_d = cnt_q;
         wdata_d = '0;
         cnt_d   = cnt_q + ALEN'(1);
         if (cnt_q == LAST) begin
            state_d = RUN;
            done_d  = 1'b1;
         end
      end else if ((lsu_acc | alu_acc) && acc_addr != '0) begin
         wen_d   = 1'b1;
         waddr_d = acc_addr;
         wdata_d = acc_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         cnt_q   <= ALEN'(1);
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
      end
   end

   assign o_wen       = wen_q;
   assign o_waddr     = waddr_q;
   assign o_wdata     = wdata_q;
   assign o_init_done = done_q;

`ifdef RF_WB_BYPASS_EN
   // x0 reads are hardwired zero in the register file, so never forward to them.
   assign o_byp_a_hit = wen_q & (waddr_q == i_raddr_a) & (i_raddr_a != '0);
   assign o_byp_b_hit = wen_q & (waddr_q == i_raddr_b) & (i_raddr_b != '0);
   assign o_byp_data  = wdata_q;
`endif
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb_rf_wb_ctrl: scoreboard bench for rf_wb_ctrl.
module tb_rf_wb_ctrl;
   localparam int DLEN = 32;
   localparam int ALEN = 5;
   localparam int RF_WORDS = 1 << ALEN;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            i_alu_valid = 1'b0;
   logic [ALEN-1:0] i_alu_addr = '0;
   logic [DLEN-1:0] i_alu_data = '0;
   logic            o_alu_ready;
   logic            i_lsu_valid = 1'b0;
   logic [ALEN-1:0] i_lsu_addr = '0;
   logic [DLEN-1:0] i_lsu_data = '0;
   logic            o_lsu_ready;
   logic            o_wen;
   logic [ALEN-1:0] o_waddr;
   logic [DLEN-1:0] o_wdata;
   logic            o_init_done;
`ifdef RF_WB_BYPASS_EN
   logic [ALEN-1:0] i_raddr_a = '0;
   logic [ALEN-1:0] i_raddr_b = '0;
   logic            o_byp_a_hit;
   logic            o_byp_b_hit;
   logic [DLEN-1:0] o_byp_data;
`endif

   rf_wb_ctrl #(.DLEN(DLEN), .ALEN(ALEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_alu_valid(i_alu_valid), .i_alu_addr(i_alu_addr), .i_alu_data(i_alu_data),
      .o_alu_ready(o_alu_ready),
      .i_lsu_valid(i_lsu_valid), .i_lsu_addr(i_lsu_addr), .i_lsu_data(i_lsu_data),
      .o_lsu_ready(o_lsu_ready),
      .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_init_done(o_init_done)
`ifdef RF_WB_BYPASS_EN
      , .i_raddr_a(i_raddr_a), .i_raddr_b(i_raddr_b),
      .o_byp_a_hit(o_byp_a_hit), .o_byp_b_hit(o_byp_b_hit), .o_byp_data(o_byp_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ALEN-1:0] a;
      logic [DLEN-1:0] d;
   } wr_t;

   wr_t exp_q[$];
   wr_t e;
   int  n_run = 0;
   int  n_fail = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      n_run++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endfunction

   // Monitor: every write presented on the port must match the next expected one.
   always @(negedge clk) begin
      if (o_wen === 1'b1) begin
         chk("wen_to_x0", 32'(o_waddr == '0), 32'd0);
         if (exp_q.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL unexpected_write actual=x%0d:0x%0h required=none", o_waddr, o_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("waddr", 32'(o_waddr), 32'(e.a));
            chk("wdata", o_wdata, e.d);
         end
      end
   end

   task automatic chk_reset(string tag);
      chk({tag, "_wen"}, 32'(o_wen), 32'd0);
      chk({tag, "_waddr"}, 32'(o_waddr), 32'd0);
      chk({tag, "_wdata"}, o_wdata, 32'd0);
      chk({tag, "_done"}, 32'(o_init_done), 32'd0);
      chk({tag, "_alu_rdy"}, 32'(o_alu_ready), 32'd0);
      chk({tag, "_lsu_rdy"}, 32'(o_lsu_ready), 32'd0);
   endtask

   // Entered with rst_n low; releases it and follows the whole zeroing sweep
   // while both producers keep requesting (those requests must be ignored).
   task automatic do_sweep();
      for (int i = 1; i < RF_WORDS; i++) exp_q.push_back('{a: ALEN'(i), d: '0});
      i_alu_valid = 1'b1; i_alu_addr = 5'd9; i_alu_data = 32'h99;
      i_lsu_valid = 1'b1; i_lsu_addr = 5'd4; i_lsu_data = 32'h44;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < RF_WORDS - 1; i++) begin
         @(negedge clk);
         #1;
         chk("init_done", 32'(o_init_done), 32'(i == RF_WORDS - 2));
         if (i < RF_WORDS - 2) begin
            chk("alu_rdy_init", 32'(o_alu_ready), 32'd0);
            chk("lsu_rdy_init", 32'(o_lsu_ready), 32'd0);
         end
         if (i == RF_WORDS - 4) begin
            i_alu_valid = 1'b0;
            i_lsu_valid = 1'b0;
         end
      end
      chk("sweep_drained", 32'(exp_q.size()), 32'd0);
   endtask

   // One RUN cycle of stimulus; the expected write follows LSU-over-ALU priority.
   task automatic req(input logic lv, input logic [ALEN-1:0] la, input logic [DLEN-1:0] ld,
                      input logic av, input logic [ALEN-1:0] aa, input logic [DLEN-1:0] ad,
                      input logic ardy);
      @(negedge clk);
      i_lsu_valid = lv; i_lsu_addr = la; i_lsu_data = ld;
      i_alu_valid = av; i_alu_addr = aa; i_alu_data = ad;
      #1;
      chk("lsu_rdy", 32'(o_lsu_ready), 32'd1);
      chk("alu_rdy", 32'(o_alu_ready), 32'(ardy));
      if (lv) begin
         if (la != '0) exp_q.push_back('{a: la, d: ld});
      end else if (av && ardy && aa != '0) exp_q.push_back('{a: aa, d: ad});
   endtask

   task automatic idle();
      @(negedge clk);
      i_lsu_valid = 1'b0;
      i_alu_valid = 1'b0;
   endtask

   initial begin
      logic lv, av;
      logic [ALEN-1:0] la, aa;
      logic [DLEN-1:0] ld, ad;
      #2 rst_n = 1'b0;
      #1 chk_reset("por");
      do_sweep();

      req(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
      idle();

      req(1'b1, 5'd7, 32'h11, 1'b1, 5'd8, 32'h22, 1'b0);
      req(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h22, 1'b1);
      idle();

      req(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1);
      idle();
      #1;
      chk("alu_x0_wen", 32'(o_wen), 32'd0);
      chk("x0_waddr_hold", 32'(o_waddr), 32'd8);
      chk("x0_wdata_hold", o_wdata, 32'h22);
      req(1'b1, 5'd0, 32'hAB, 1'b0, 5'd0, 32'h0, 1'b0);
      idle();
      #1 chk("lsu_x0_wen", 32'(o_wen), 32'd0);

      req(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB1, 1'b0);
      req(1'b1, 5'd12, 32'hA1, 1'b1, 5'd11, 32'hB1, 1'b0);
      req(1'b1, 5'd31, 32'hA2, 1'b1, 5'd11, 32'hB1, 1'b0);
      req(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hB1, 1'b1);
      idle();

`ifdef RF_WB_BYPASS_EN
      req(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hA5, 1'b1);
      idle();
      i_raddr_a = 5'd3; i_raddr_b = 5'd0;
      #1;
      chk("byp_a_hit", 32'(o_byp_a_hit), 32'd1);
      chk("byp_b_hit", 32'(o_byp_b_hit), 32'd0);
      chk("byp_data", o_byp_data, 32'hA5);
      @(negedge clk);
      #1 chk("byp_a_idle", 32'(o_byp_a_hit), 32'd0);
      i_raddr_a = '0;
`endif

      for (int k = 0; k < 2000; k++) begin
         lv = 1'($urandom_range(0, 1)); la = ALEN'($urandom_range(0, 7)); ld = $urandom;
         av = 1'($urandom_range(0, 1)); aa = ALEN'($urandom_range(0, 7)); ad = $urandom;
         req(lv, la, ld, av, aa, ad, ~lv);
      end
      idle();
      idle();
      chk("run_drained", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of the sweep, once x12 has been presented.
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      for (int i = 1; i <= 12; i++) exp_q.push_back('{a: ALEN'(i), d: '0});
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      #1 chk("mid_sweep_addr", 32'(o_waddr), 32'd12);
      #1 rst_n = 1'b0;
      #1 chk_reset("sweep_rst");
      exp_q.delete();
      do_sweep();

      // Reset while an accepted ALU request is about to be written.
      @(negedge clk);
      i_alu_valid = 1'b1; i_alu_addr = 5'd9; i_alu_data = 32'h99;
      #1 chk("pending_alu_rdy", 32'(o_alu_ready), 32'd1);
      #1 rst_n = 1'b0;
      #1 chk_reset("run_rst");
      do_sweep();
      idle();
      idle();
      chk("final_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
